// File: rtl/mod_counter_pkg.sv
// Shared constants, types and helpers for the mod-N BCD counter and its display scanner.
package mod_counter_pkg;

  localparam int unsigned MAX_DIGITS = 4;
  localparam int unsigned BCD_W      = 4 * MAX_DIGITS;

  typedef logic [3:0] bcd_t;

  // Glyphs as {a,b,c,d,e,f,g,dp}, active-high
  localparam logic [7:0] SEG_0     = 8'b11111100;
  localparam logic [7:0] SEG_1     = 8'b01100000;
  localparam logic [7:0] SEG_2     = 8'b11011010;
  localparam logic [7:0] SEG_3     = 8'b11110010;
  localparam logic [7:0] SEG_4     = 8'b01100110;
  localparam logic [7:0] SEG_5     = 8'b10110110;
  localparam logic [7:0] SEG_6     = 8'b10111110;
  localparam logic [7:0] SEG_7     = 8'b11100000;
  localparam logic [7:0] SEG_8     = 8'b11111110;
  localparam logic [7:0] SEG_9     = 8'b11110110;
  localparam logic [7:0] SEG_BLANK = 8'b00000000;

  // Elaboration-time binary to packed BCD (digit 0 in the low nibble)
  function automatic logic [BCD_W-1:0] to_bcd(input int value);
    logic [BCD_W-1:0] r;
    int v;
    r = '0;
    v = value;
    for (int d = 0; d < int'(MAX_DIGITS); d++) begin
      r[d*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Run-time binary to BCD by shift-and-add-3; inputs stay below 10000
  function automatic logic [BCD_W-1:0] bin2bcd(input logic [13:0] bin);
    logic [BCD_W-1:0] r;
    r = '0;
    for (int i = 13; i >= 0; i--) begin
      for (int d = 0; d < int'(MAX_DIGITS); d++) begin
        if (r[d*4 +: 4] >= 4'd5) r[d*4 +: 4] = r[d*4 +: 4] + 4'd3;
      end
      r = {r[BCD_W-2:0], bin[i]};
    end
    return r;
  endfunction

  // BCD +1 with per-digit carry
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    logic carry;
    r = b;
    carry = 1'b1;
    for (int d = 0; d < int'(MAX_DIGITS); d++) begin
      if (carry) begin
        if (r[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // BCD -1 with per-digit borrow
  function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    logic borrow;
    r = b;
    borrow = 1'b1;
    for (int d = 0; d < int'(MAX_DIGITS); d++) begin
      if (borrow) begin
        if (r[d*4 +: 4] == 4'd0) begin
          r[d*4 +: 4] = 4'd9;
        end else begin
          r[d*4 +: 4] = r[d*4 +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Digit to segment glyph
  function automatic logic [7:0] seg_glyph(input bcd_t d);
    logic [7:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/modn_bcd_counter_seg7_scan.sv
// Multiplexed common-anode 7-segment scanner with optional leading-zero blanking.
module seg7_scan
  import mod_counter_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 2,
  parameter int unsigned SCAN_DIV   = 2000,
  parameter int unsigned BLANK_LZ   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bcd,
  output logic [7:0]  segment,
  output logic [3:0]  ctrl
);

  localparam int unsigned SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SC_W-1:0] SC_LAST  = SC_W'(SCAN_DIV - 1);
  localparam logic [1:0]      IDX_LAST = 2'(NUM_DIGITS - 1);

  logic [SC_W-1:0] sc_q, sc_d;
  logic [1:0]      idx_q, idx_d;
  bcd_t            digit;
  logic [3:0]      blank_vec;
  logic            zero_above;
  logic [7:0]      seg_d;
  logic [3:0]      ctrl_d;

  // Scan counter and digit index advance, free-running
  always_comb begin
    sc_d  = sc_q + SC_W'(1);
    idx_d = idx_q;
    if (sc_q == SC_LAST) begin
      sc_d  = '0;
      idx_d = (idx_q == IDX_LAST) ? 2'd0 : idx_q + 2'd1;
    end
  end

  // A digit is blank when it and every digit above it are zero; digit 0 never is
  always_comb begin
    blank_vec  = '0;
    zero_above = 1'b1;
    for (int k = 3; k >= 1; k--) begin
      zero_above   = zero_above && (bcd[4*k +: 4] == 4'd0);
      blank_vec[k] = (BLANK_LZ != 0) && zero_above;
    end
  end

  // Glyph and anode select for the current index
  always_comb begin
    digit  = 4'(bcd >> {idx_q, 2'b00});
    seg_d  = blank_vec[idx_q] ? SEG_BLANK : seg_glyph(digit);
    ctrl_d = ~(4'b1000 >> idx_q);
  end

  // Scan state and display output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sc_q    <= '0;
      idx_q   <= 2'd0;
      segment <= SEG_BLANK;
      ctrl    <= 4'b1111;
    end else begin
      sc_q    <= sc_d;
      idx_q   <= idx_d;
      segment <= seg_d;
      ctrl    <= ctrl_d;
    end
  end

endmodule

// File: rtl/modn_bcd_counter.sv
// Modulo-N up/down counter with prescaler, load, terminal-count pulse and BCD display.
module modn_bcd_counter
  import mod_counter_pkg::*;
#(
  parameter int unsigned MODULUS    = 12,
  parameter int unsigned NUM_DIGITS = 2,
  parameter int unsigned TICK_DIV   = 2000000,
  parameter int unsigned SCAN_DIV   = 2000,
  parameter int unsigned BLANK_LZ   = 0,
  parameter int unsigned CNT_W      = $clog2(MODULUS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] q,
  output logic             tc,
  output logic [7:0]       segment,
  output logic [3:0]       ctrl
);

  localparam int unsigned PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] Q_LAST   = CNT_W'(MODULUS - 1);
  localparam logic [15:0]      WRAP_BCD = to_bcd(int'(MODULUS - 1));

  logic [PS_W-1:0]  ps_q, ps_d;
  logic [CNT_W-1:0] q_d, load_clamped;
  logic [15:0]      bcd_q, bcd_d;
  logic             tc_d;
  logic             tick;

  // Prescaler tick and out-of-range load clamp
  assign tick         = en && (ps_q == PS_LAST);
  assign load_clamped = ({1'b0, load_val} >= (CNT_W+1)'(MODULUS)) ? Q_LAST : load_val;

  // Next count: load wins over tick; wrap steps raise tc
  always_comb begin
    ps_d  = ps_q;
    q_d   = q;
    bcd_d = bcd_q;
    tc_d  = 1'b0;
    if (load) begin
      q_d   = load_clamped;
      bcd_d = bin2bcd(14'(load_clamped));
      ps_d  = '0;
    end else begin
      if (en) ps_d = tick ? '0 : ps_q + PS_W'(1);
      if (tick) begin
        if (up) begin
          if (q == Q_LAST) begin
            q_d   = '0;
            bcd_d = '0;
            tc_d  = 1'b1;
          end else begin
            q_d   = q + CNT_W'(1);
            bcd_d = bcd_inc(bcd_q);
          end
        end else begin
          if (q == '0) begin
            q_d   = Q_LAST;
            bcd_d = WRAP_BCD;
            tc_d  = 1'b1;
          end else begin
            q_d   = q - CNT_W'(1);
            bcd_d = bcd_dec(bcd_q);
          end
        end
      end
    end
  end

  // Counter state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps_q  <= '0;
      q     <= '0;
      bcd_q <= '0;
      tc    <= 1'b0;
    end else begin
      ps_q  <= ps_d;
      q     <= q_d;
      bcd_q <= bcd_d;
      tc    <= tc_d;
    end
  end

  seg7_scan #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV),
    .BLANK_LZ   (BLANK_LZ)
  ) u_scan (
    .clk     (clk),
    .reset   (reset),
    .bcd     (bcd_q),
    .segment (segment),
    .ctrl    (ctrl)
  );

endmodule

// File: tb/tb_modn_bcd_counter.sv
// Bench for modn_bcd_counter: reference-model scoreboard on a mod-12 instance plus
// directed display checks on two mod-1000 four-digit instances.
module tb_modn_bcd_counter;

  localparam int M_A = 12;
  localparam int TD  = 4;
  localparam int SD  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       en_a, up_a, load_a;
  logic [3:0] lv_a, q_a, ctrl_a, ctrl_b, ctrl_c;
  logic       tc_a, tc_b, tc_c;
  logic [7:0] seg_a, seg_b, seg_c;
  logic       en_b, up_b, load_b;
  logic [9:0] lv_b, q_b, q_c;

  modn_bcd_counter #(.MODULUS(12), .NUM_DIGITS(2), .TICK_DIV(TD), .SCAN_DIV(SD), .BLANK_LZ(0)) dut_a (
    .clk(clk), .reset(reset), .en(en_a), .up(up_a), .load(load_a), .load_val(lv_a),
    .q(q_a), .tc(tc_a), .segment(seg_a), .ctrl(ctrl_a));

  modn_bcd_counter #(.MODULUS(1000), .NUM_DIGITS(4), .TICK_DIV(TD), .SCAN_DIV(SD), .BLANK_LZ(1)) dut_b (
    .clk(clk), .reset(reset), .en(en_b), .up(up_b), .load(load_b), .load_val(lv_b),
    .q(q_b), .tc(tc_b), .segment(seg_b), .ctrl(ctrl_b));

  modn_bcd_counter #(.MODULUS(1000), .NUM_DIGITS(4), .TICK_DIV(TD), .SCAN_DIV(SD), .BLANK_LZ(0)) dut_c (
    .clk(clk), .reset(reset), .en(en_b), .up(up_b), .load(load_b), .load_val(lv_b),
    .q(q_c), .tc(tc_c), .segment(seg_c), .ctrl(ctrl_c));

  typedef struct {
    int         q;
    logic       tc;
    logic [3:0] ctrl;
    logic [7:0] seg;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  int   m_q, m_ps, m_sc, m_idx;
  logic m_tc;

  logic [7:0] glyph [0:9] = '{8'b11111100, 8'b01100000, 8'b11011010, 8'b11110010, 8'b01100110,
                              8'b10110110, 8'b10111110, 8'b11100000, 8'b11111110, 8'b11110110};
  logic [3:0] ctrl_tab [0:3] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_ps = 0; m_sc = 0; m_idx = 0; m_tc = 1'b0;
  endtask

  // One clock on the mod-12 instance: predict, push, clock, pop and compare
  task automatic step_a();
    exp_t e;
    int   dig;
    bit   tick;
    dig    = (m_idx == 0) ? (m_q % 10) : (m_q / 10);
    e.ctrl = ctrl_tab[m_idx];
    e.seg  = glyph[dig];
    tick   = en_a && (m_ps == TD - 1);
    m_tc   = 1'b0;
    if (load_a) begin
      m_q  = (int'(lv_a) >= M_A) ? M_A - 1 : int'(lv_a);
      m_ps = 0;
    end else begin
      if (en_a) m_ps = (m_ps == TD - 1) ? 0 : m_ps + 1;
      if (tick) begin
        if (up_a) begin
          if (m_q == M_A - 1) begin m_q = 0; m_tc = 1'b1; end
          else m_q = m_q + 1;
        end else begin
          if (m_q == 0) begin m_q = M_A - 1; m_tc = 1'b1; end
          else m_q = m_q - 1;
        end
      end
    end
    if (m_sc == SD - 1) begin
      m_sc  = 0;
      m_idx = (m_idx == 1) ? 0 : m_idx + 1;
    end else begin
      m_sc = m_sc + 1;
    end
    e.q  = m_q;
    e.tc = m_tc;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    chk("q_a",    16'(q_a),    16'(e.q));
    chk("tc_a",   16'(tc_a),   16'(e.tc));
    chk("ctrl_a", 16'(ctrl_a), 16'(e.ctrl));
    chk("seg_a",  16'(seg_a),  16'(e.seg));
  endtask

  initial begin
    int cnt;
    reset = 1'b1;
    en_a = 1'b0; up_a = 1'b1; load_a = 1'b0; lv_a = '0;
    en_b = 1'b0; up_b = 1'b1; load_b = 1'b0; lv_b = '0;
    #2 reset = 1'b0;
    #1;
    chk("rst_q",    16'(q_a),    16'd0);
    chk("rst_tc",   16'(tc_a),   16'd0);
    chk("rst_ctrl", 16'(ctrl_a), 16'(4'b1111));
    chk("rst_seg",  16'(seg_a),  16'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();

    // Count up through the 11->0 wrap, landing on q=0 just after the wrap
    en_a = 1'b1;
    repeat (48) step_a();
    chk("wrap_up_q", 16'(q_a), 16'd0);

    // Down from 0: wrap to 11, then 10
    up_a = 1'b0;
    repeat (8) step_a();
    up_a = 1'b1;

    // Load coincident with a tick
    cnt = 0;
    while (m_ps != TD - 1 && cnt < 8) begin step_a(); cnt++; end
    load_a = 1'b1; lv_a = 4'd7;
    step_a();
    load_a = 1'b0;
    chk("load7_q", 16'(q_a), 16'd7);
    repeat (4) step_a();

    // Out-of-range load clamps to MODULUS-1, then wraps up
    load_a = 1'b1; lv_a = 4'd14;
    step_a();
    load_a = 1'b0;
    chk("load14_q", 16'(q_a), 16'd11);
    repeat (4) step_a();

    // Enable hold mid-period
    cnt = 0;
    while (m_ps != 2 && cnt < 8) begin step_a(); cnt++; end
    en_a = 1'b0;
    repeat (10) step_a();
    en_a = 1'b1;
    repeat (4) step_a();

    // Four-digit display of q=5 with and without leading-zero blanking
    load_b = 1'b1; lv_b = 10'd5;
    step_a();
    load_b = 1'b0;
    chk("load5_qb", 16'(q_b), 16'd5);
    chk("load5_qc", 16'(q_c), 16'd5);
    cnt = 0;
    while (ctrl_b !== 4'b1110 && cnt < 20) begin step_a(); cnt++; end
    chk("wait_slot3", 16'(ctrl_b), 16'(4'b1110));
    cnt = 0;
    while (ctrl_b === 4'b1110 && cnt < 5) begin step_a(); cnt++; end
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < SD; j++) begin
        chk("ctrl_b", 16'(ctrl_b), 16'(ctrl_tab[k]));
        chk("seg_b",  16'(seg_b),  16'((k == 0) ? 8'b10110110 : 8'b00000000));
        chk("ctrl_c", 16'(ctrl_c), 16'(ctrl_tab[k]));
        chk("seg_c",  16'(seg_c),  16'((k == 0) ? 8'b10110110 : 8'b11111100));
        step_a();
      end
    end

    // Asynchronous reset mid-scan with q=9
    en_a = 1'b0;
    load_a = 1'b1; lv_a = 4'd9;
    step_a();
    load_a = 1'b0;
    repeat (2) step_a();
    chk("pre_rst_q", 16'(q_a), 16'd9);
    #2 reset = 1'b0;
    #1;
    chk("arst_q",    16'(q_a),    16'd0);
    chk("arst_tc",   16'(tc_a),   16'd0);
    chk("arst_ctrl", 16'(ctrl_a), 16'(4'b1111));
    chk("arst_seg",  16'(seg_a),  16'd0);
    chk("arst_qb",   16'(q_b),    16'd0);
    chk("arst_ctrlb",16'(ctrl_b), 16'(4'b1111));
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    step_a();
    chk("first_ctrl", 16'(ctrl_a), 16'(4'b0111));
    chk("first_seg",  16'(seg_a),  16'(8'b11111100));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/modn_bcd_counter.md
# modn_bcd_counter

Parametrised modulo-N up/down counter with a built-in tick prescaler, load, and a terminal-count pulse. It keeps the count in binary and in BCD and drives a multiplexed common-anode 7-segment display of up to 4 digits. It generalises the board's fixed mod-12 two-digit counter/display and sits directly on the FPGA top level, between the board clock and reset and the display pins.

## Interface
- MODULUS, 12: count range 0..MODULUS-1; legal 2..10**NUM_DIGITS.
- NUM_DIGITS, 2: displayed digits, legal 1..4.
- TICK_DIV, 2000000: clk cycles per count tick, legal >=1; 1 means every cycle.
- SCAN_DIV, 2000: clk cycles per display digit slot, legal >=1.
- BLANK_LZ, 0: 1 blanks leading zero digits; digit 0 is never blanked.
- CNT_W, derived: $clog2(MODULUS).
- clk  in  1  single system clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  count enable; it also gates the prescaler.
- up  in  1  1 = count up, 0 = count down; sampled on each tick.
- load  in  1  synchronous load strobe.
- load_val  in  CNT_W  load value.
- q  out  CNT_W  binary count, registered.
- tc  out  1  one-clk pulse, registered, asserted after a wrap step.
- segment  out  8  segment bits {a,b,c,d,e,f,g,dp}, active-high; dp is always 0.
- ctrl  out  4  digit anodes, active-low; digit k (k=0 is units) is selected by ctrl[3-k]=0.

## Operation
- Prescaler counts 0..TICK_DIV-1 while en=1 and holds while en=0. Reaching TICK_DIV-1 produces an internal tick for one clk and the prescaler returns to 0.
- Priority per clk: load, then tick step.
- Load sets q to load_val. If load_val >= MODULUS, q is set to MODULUS-1 instead. The BCD digits are set to the matching value and the prescaler clears to 0. A tick in the same cycle is discarded. tc is not asserted on a load.
- Tick step, up: q = MODULUS-1 steps to 0 (wrap), otherwise q+1.
- Tick step, down: q = 0 steps to MODULUS-1 (wrap), otherwise q-1.
- tc goes high for exactly one clk, in the cycle after a wrap step.
- BCD digits track q in the same cycle. They are updated by per-digit carry/borrow, with no division.
- Wrap load values come from MODULUS-1 converted to BCD at elaboration.
- Scan: a scan counter runs 0..SCAN_DIV-1 continuously and ignores en. On its wrap, the digit index advances 0 -> 1 -> ... -> NUM_DIGITS-1 -> 0.
- Display registers are updated every clk from the current index and BCD digit:
  - ctrl has a single 0 at position 3-index; all other bits are 1, including unused digits.
  - segment is the glyph of the current digit, or all zeros if it is blanked.
- Glyphs: 0=11111100, 1=01100000, 2=11011010, 3=11110010, 4=01100110, 5=10110110, 6=10111110, 7=11100000, 8=11111110, 9=11110110.

## Timing
- Reset (async assert, deassert on the clk edge) gives q=0, tc=0, BCD=0, prescaler=0, scan counter=0, index=0, ctrl=4'b1111, segment=8'b00000000.
- First clk edge after reset release: ctrl shows digit 0 and segment=11111100.
- Count latency: q changes on the clk edge where the tick and en are both 1. For TICK_DIV=N, the first step lands on the Nth enabled edge.
- Display latency: 1 clk from a q/BCD change or an index change to segment/ctrl.
- en toggling mid-period freezes and resumes the prescaler phase; it is not reset.
- Reset asserted mid-count or mid-scan gives immediate reset values on all outputs, independent of clk.

## Structure
- Package mod_counter_pkg holds:
  - SEG_0..SEG_9 and SEG_BLANK constants;
  - the function to_bcd(int) used for elaboration-time wrap constants;
  - the BCD digit typedef (4 bits).
- Sub-module seg7_scan holds the scan counter, the digit index, leading-zero blanking, and the glyph decode with ctrl/segment registers. Its parameters are NUM_DIGITS, SCAN_DIV and BLANK_LZ.
- The top level holds the prescaler, the binary and BCD count, load and tc.

## Test plan
- MODULUS=12, TICK_DIV=4, up=1, en=1 from reset: q steps every 4 clks, 0..11. The step 11->0 produces tc=1 for exactly one clk, and BCD reads 1,1 then 0,0.
- up=0 at q=0: the next tick gives q=11, BCD 1,1 and one tc pulse. A further tick gives q=10.
- load=1, load_val=7, coincident with a tick: q=7 on that edge, no step, no tc, and the next step comes 4 clks later. load_val=14 gives q=11.
- en=0 after 2 prescaler cycles for 10 clks, then en=1: the step occurs 2 enabled clks later and q is unchanged during the hold.
- SCAN_DIV=3, NUM_DIGITS=4, MODULUS=1000, q=5, BLANK_LZ=1:
  - ctrl cycles 0111, 1011, 1101, 1110, each held 3 clks;
  - segment is 10110110 for digit 0 and 00000000 for the others.
  - With BLANK_LZ=0, the other digits show 11111100.
- Reset pulsed low mid-scan with q=9: q=0, tc=0, ctrl=1111 and segment=0 immediately. The first edge after release shows ctrl=0111, segment=11111100.
